// File: rtl/score_keeper.sv
// Pong score keeper: edge-detects play/goal inputs, sequences serve/run/pause/over
// and keeps saturating per-player scores, serve direction and the winner.
module score_keeper #(
  parameter int WIN_SCORE   = 5,
  parameter int SERVE_DELAY = 60
) (
  input  logic       dyn_clk,
  input  logic       reset,
  input  logic       play,
  input  logic       reset_goals,
  input  logic       goal_ply1,
  input  logic       goal_ply2,
  output logic [3:0] score_ply1,
  output logic [3:0] score_ply2,
  output logic       run,
  output logic       serve_dir,
  output logic       game_over,
  output logic [1:0] winner
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SERVE = 3'd1,
    RUN   = 3'd2,
    PAUSE = 3'd3,
    OVER  = 3'd4
  } state_t;

  localparam logic [3:0] WIN  = 4'(WIN_SCORE);
  localparam logic [7:0] LAST = 8'(SERVE_DELAY - 1);

  state_t     state;
  logic [7:0] serve_cnt;
  logic       play_q, g1_q, g2_q;
  logic       play_e, g1_e, g2_e;
  logic [3:0] s1_inc, s2_inc;

  assign play_e = play & ~play_q;
  assign g1_e   = goal_ply1 & ~g1_q;
  assign g2_e   = goal_ply2 & ~g2_q;

  // Saturating increments; scores never pass WIN_SCORE.
  assign s1_inc = (score_ply1 >= WIN) ? WIN : score_ply1 + 4'd1;
  assign s2_inc = (score_ply2 >= WIN) ? WIN : score_ply2 + 4'd1;

  always_ff @(posedge dyn_clk or negedge reset) begin
    if (!reset) begin
      play_q <= 1'b0;
      g1_q   <= 1'b0;
      g2_q   <= 1'b0;
    end else begin
      play_q <= play;
      g1_q   <= goal_ply1;
      g2_q   <= goal_ply2;
    end
  end

  // run and game_over are loaded alongside every state change so they track state.
  always_ff @(posedge dyn_clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      serve_cnt  <= 8'd0;
      score_ply1 <= 4'd0;
      score_ply2 <= 4'd0;
      winner     <= 2'd0;
      serve_dir  <= 1'b1;
      run        <= 1'b0;
      game_over  <= 1'b0;
    end else if (reset_goals) begin
      state      <= IDLE;
      serve_cnt  <= 8'd0;
      score_ply1 <= 4'd0;
      score_ply2 <= 4'd0;
      winner     <= 2'd0;
      serve_dir  <= 1'b1;
      run        <= 1'b0;
      game_over  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (play_e) begin
            state     <= SERVE;
            serve_cnt <= 8'd0;
          end
        end
        SERVE: begin
          serve_cnt <= serve_cnt + 8'd1;
          if (serve_cnt == LAST) begin
            state <= RUN;
            run   <= 1'b1;
          end
        end
        RUN: begin
          // Goals outrank play; a simultaneous pair is a void rally.
          if (g1_e && g2_e) begin
            state     <= SERVE;
            serve_cnt <= 8'd0;
            run       <= 1'b0;
          end else if (g1_e) begin
            score_ply1 <= s1_inc;
            serve_dir  <= 1'b0;
            serve_cnt  <= 8'd0;
            run        <= 1'b0;
            if (s1_inc == WIN) begin
              state     <= OVER;
              winner    <= 2'd1;
              game_over <= 1'b1;
            end else begin
              state <= SERVE;
            end
          end else if (g2_e) begin
            score_ply2 <= s2_inc;
            serve_dir  <= 1'b1;
            serve_cnt  <= 8'd0;
            run        <= 1'b0;
            if (s2_inc == WIN) begin
              state     <= OVER;
              winner    <= 2'd2;
              game_over <= 1'b1;
            end else begin
              state <= SERVE;
            end
          end else if (play_e) begin
            state <= PAUSE;
            run   <= 1'b0;
          end
        end
        PAUSE: begin
          if (play_e) begin
            state <= RUN;
            run   <= 1'b1;
          end
        end
        OVER: begin
          if (play_e) begin
            state      <= SERVE;
            serve_cnt  <= 8'd0;
            score_ply1 <= 4'd0;
            score_ply2 <= 4'd0;
            winner     <= 2'd0;
            serve_dir  <= 1'b1;
            game_over  <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          run       <= 1'b0;
          game_over <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_score_keeper.sv
// Directed scenarios plus a randomized run, all checked against a behavioural
// game model that counts serve time down and tracks the game phase.
module tb_score_keeper;
  localparam int W = 3;
  localparam int D = 4;
  localparam logic [12:0] RST_VEC = 13'b0000_0000_0_1_0_00;

  localparam int P_IDLE  = 0;
  localparam int P_SERVE = 1;
  localparam int P_RUN   = 2;
  localparam int P_PAUSE = 3;
  localparam int P_OVER  = 4;

  logic       dyn_clk = 1'b0;
  logic       reset, play, reset_goals, goal_ply1, goal_ply2;
  logic [3:0] score_ply1, score_ply2;
  logic       run, serve_dir, game_over;
  logic [1:0] winner;
  logic [12:0] dut_vec;

  int checks = 0;
  int errors = 0;

  int m_phase, m_left, m_s1, m_s2, m_win;
  bit m_dir, m_pp, m_p1, m_p2;

  score_keeper #(.WIN_SCORE(W), .SERVE_DELAY(D)) dut (
    .dyn_clk(dyn_clk), .reset(reset), .play(play), .reset_goals(reset_goals),
    .goal_ply1(goal_ply1), .goal_ply2(goal_ply2),
    .score_ply1(score_ply1), .score_ply2(score_ply2), .run(run),
    .serve_dir(serve_dir), .game_over(game_over), .winner(winner)
  );

  always #5 dyn_clk = ~dyn_clk;

  assign dut_vec = {score_ply1, score_ply2, run, serve_dir, game_over, winner};

  function automatic logic [12:0] m_out();
    logic [3:0] a, b;
    logic [1:0] w;
    a = m_s1[3:0];
    b = m_s2[3:0];
    w = m_win[1:0];
    return {a, b, (m_phase == P_RUN), m_dir, (m_phase == P_OVER), w};
  endfunction

  task automatic m_reset();
    m_phase = P_IDLE; m_left = 0; m_s1 = 0; m_s2 = 0; m_win = 0;
    m_dir = 1'b1; m_pp = 1'b0; m_p1 = 1'b0; m_p2 = 1'b0;
  endtask

  task automatic m_new_serve();
    m_phase = P_SERVE;
    m_left  = D;
  endtask

  task automatic m_step(input bit p, input bit rg, input bit g1, input bit g2);
    bit pe, e1, e2;
    pe = p & ~m_pp; e1 = g1 & ~m_p1; e2 = g2 & ~m_p2;
    m_pp = p; m_p1 = g1; m_p2 = g2;
    if (rg) begin
      m_phase = P_IDLE; m_s1 = 0; m_s2 = 0; m_win = 0; m_dir = 1'b1;
    end else begin
      case (m_phase)
        P_IDLE:  if (pe) m_new_serve();
        P_SERVE: begin
          m_left--;
          if (m_left == 0) m_phase = P_RUN;
        end
        P_RUN: begin
          if (e1 && e2) m_new_serve();
          else if (e1) begin
            m_s1 = (m_s1 < W) ? m_s1 + 1 : W;
            m_dir = 1'b0;
            if (m_s1 == W) begin m_phase = P_OVER; m_win = 1; end
            else m_new_serve();
          end else if (e2) begin
            m_s2 = (m_s2 < W) ? m_s2 + 1 : W;
            m_dir = 1'b1;
            if (m_s2 == W) begin m_phase = P_OVER; m_win = 2; end
            else m_new_serve();
          end else if (pe) m_phase = P_PAUSE;
        end
        P_PAUSE: if (pe) m_phase = P_RUN;
        P_OVER: if (pe) begin
          m_s1 = 0; m_s2 = 0; m_win = 0; m_dir = 1'b1;
          m_new_serve();
        end
        default: m_phase = P_IDLE;
      endcase
    end
  endtask

  task automatic tick(input bit p, input bit rg, input bit g1, input bit g2);
    play = p; reset_goals = rg; goal_ply1 = g1; goal_ply2 = g2;
    @(posedge dyn_clk);
    m_step(p, rg, g1, g2);
    #1;
  endtask

  task automatic wait_run(input string nm);
    int n = 0;
    while (run !== 1'b1 && n < 20) begin
      tick(0, 0, 0, 0);
      n++;
    end
    checks++;
    if (run !== 1'b1) begin
      errors++;
      $display("FAIL %s_wait_run: run=%b after %0d cycles, required 1", nm, run, n);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; play = 0; reset_goals = 0; goal_ply1 = 0; goal_ply2 = 0;
    m_reset();
    repeat (2) @(posedge dyn_clk);
    #1;
    checks++;
    if (dut_vec !== RST_VEC) begin
      errors++; $display("FAIL reset_state: got %h required %h", dut_vec, RST_VEC);
    end
    @(negedge dyn_clk);
    reset = 1'b1;
    tick(0, 0, 0, 0);
    checks++;
    if (dut_vec !== RST_VEC) begin
      errors++; $display("FAIL reset_release: got %h required %h", dut_vec, RST_VEC);
    end
  endtask

  task automatic test_serve_timing();
    int n = 0;
    tick(1, 0, 0, 0);
    checks++;
    if (run !== 1'b0) begin
      errors++; $display("FAIL serve_enter: run=%b required 0", run);
    end
    while (run !== 1'b1 && n < 20) begin
      tick(0, 0, 0, 0);
      n++;
    end
    checks++;
    if (n != D || run !== 1'b1) begin
      errors++; $display("FAIL serve_len: run rose after %0d cycles, required %0d", n, D);
    end
  endtask

  task automatic test_goal_count();
    int low = 0;
    for (int i = 0; i < 5; i++) begin
      tick(0, 0, 1, 0);
      if (run !== 1'b1) low++;
      if (i == 0) begin
        checks++;
        if (score_ply1 !== 4'd1 || serve_dir !== 1'b0) begin
          errors++; $display("FAIL goal_first: score1=%0d dir=%b required 1/0", score_ply1, serve_dir);
        end
      end
    end
    checks++;
    if (score_ply1 !== 4'd1 || low != D || run !== 1'b1) begin
      errors++;
      $display("FAIL goal_held: score1=%0d low=%0d run=%b required 1/%0d/1", score_ply1, low, run, D);
    end
    tick(0, 0, 0, 0);
  endtask

  task automatic test_win();
    for (int k = 0; k < 3; k++) begin
      wait_run("win");
      tick(0, 0, 0, 1);
      tick(0, 0, 0, 0);
    end
    checks++;
    if (score_ply2 !== 4'd3 || game_over !== 1'b1 || winner !== 2'd2 || run !== 1'b0) begin
      errors++;
      $display("FAIL win_state: s2=%0d over=%b win=%0d run=%b required 3/1/2/0",
               score_ply2, game_over, winner, run);
    end
    tick(0, 0, 0, 1);
    tick(0, 0, 0, 0);
    checks++;
    if (score_ply2 !== 4'd3 || game_over !== 1'b1 || winner !== 2'd2) begin
      errors++; $display("FAIL win_saturate: s2=%0d over=%b required 3/1", score_ply2, game_over);
    end
  endtask

  task automatic test_simultaneous();
    int n = 0;
    tick(1, 0, 0, 0);
    tick(0, 0, 0, 0);
    checks++;
    if (dut_vec !== RST_VEC) begin
      errors++; $display("FAIL over_restart: got %h required %h", dut_vec, RST_VEC);
    end
    wait_run("sim_a");
    tick(0, 0, 1, 0);
    tick(0, 0, 0, 0);
    wait_run("sim_b");
    tick(0, 0, 1, 1);
    checks++;
    if (score_ply1 !== 4'd1 || score_ply2 !== 4'd0 || serve_dir !== 1'b0 || run !== 1'b0) begin
      errors++;
      $display("FAIL simul_goal: s1=%0d s2=%0d dir=%b run=%b required 1/0/0/0",
               score_ply1, score_ply2, serve_dir, run);
    end
    while (run !== 1'b1 && n < 20) begin
      tick(0, 0, 0, 0);
      n++;
    end
    checks++;
    if (n != D) begin
      errors++; $display("FAIL simul_serve: run rose after %0d cycles, required %0d", n, D);
    end
  endtask

  task automatic test_pause();
    tick(1, 0, 0, 0);
    checks++;
    if (run !== 1'b0) begin
      errors++; $display("FAIL pause_enter: run=%b required 0", run);
    end
    tick(0, 0, 0, 0);
    tick(0, 0, 0, 1);
    tick(0, 0, 0, 0);
    checks++;
    if (score_ply2 !== 4'd0 || run !== 1'b0) begin
      errors++; $display("FAIL pause_goal: s2=%0d run=%b required 0/0", score_ply2, run);
    end
    tick(1, 0, 0, 0);
    checks++;
    if (run !== 1'b1) begin
      errors++; $display("FAIL pause_resume: run=%b required 1", run);
    end
    tick(0, 0, 0, 0);
  endtask

  task automatic test_play_with_goal();
    int n = 0;
    tick(1, 0, 0, 1);
    checks++;
    if (score_ply2 !== 4'd1 || run !== 1'b0 || serve_dir !== 1'b1) begin
      errors++; $display("FAIL play_goal: s2=%0d run=%b dir=%b required 1/0/1", score_ply2, run, serve_dir);
    end
    while (run !== 1'b1 && n < 20) begin
      tick(0, 0, 0, 0);
      n++;
    end
    checks++;
    if (n != D) begin
      errors++; $display("FAIL play_goal_serve: run rose after %0d cycles, required %0d", n, D);
    end
  endtask

  task automatic test_reset_goals();
    tick(0, 1, 0, 0);
    checks++;
    if (dut_vec !== RST_VEC) begin
      errors++; $display("FAIL rgoals_clear: got %h required %h", dut_vec, RST_VEC);
    end
    tick(1, 1, 0, 0);
    tick(0, 0, 0, 0);
    repeat (8) tick(0, 0, 0, 0);
    checks++;
    if (dut_vec !== RST_VEC) begin
      errors++; $display("FAIL rgoals_idle: got %h required %h", dut_vec, RST_VEC);
    end
    tick(1, 0, 0, 0);
    tick(0, 0, 0, 0);
    wait_run("rgoals");
  endtask

  task automatic test_async_reset();
    tick(0, 0, 1, 0);
    tick(0, 0, 0, 0);
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (dut_vec !== RST_VEC) begin
      errors++; $display("FAIL async_reset: got %h required %h", dut_vec, RST_VEC);
    end
    m_reset();
    @(posedge dyn_clk);
    #2;
    reset = 1'b1;
    repeat (8) tick(0, 0, 0, 0);
    checks++;
    if (dut_vec !== RST_VEC) begin
      errors++; $display("FAIL async_idle: got %h required %h", dut_vec, RST_VEC);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      tick($urandom_range(0, 5) == 0, $urandom_range(0, 79) == 0,
           $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
      checks++;
      if (dut_vec !== m_out()) begin
        errors++; $display("FAIL random_c%0d: got %h required %h", c, dut_vec, m_out());
      end
    end
  endtask

  initial begin
    test_reset();
    test_serve_timing();
    test_goal_count();
    test_win();
    test_simultaneous();
    test_pause();
    test_play_with_goal();
    test_reset_goals();
    test_async_reset();
    checks++;
    if (dut_vec !== m_out()) begin
      errors++; $display("FAIL model_sync: got %h required %h", dut_vec, m_out());
    end
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

endmodule
